// File: rtl/clock_measure_pkg.sv
// Shared types for the clock period / duty-cycle measurement block.
package clock_measure_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchroniser for an asynchronous slow input, with rise/fall strobes.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_in,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_clk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise_c = r_s2 & ~r_s3;
  assign o_fall_c = ~r_s2 & r_s3;

endmodule

// File: rtl/measure_clock_period.sv
// Measures period and high time of a slow square wave in system-clock cycles,
// with a one-cycle valid strobe per full period and a sticky dead-input flag.
module measure_clock_period
  import clock_measure_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  logic w_rise;
  logic w_fall;

  meas_state_t      r_state;
  logic [WIDTH-1:0] r_cnt_high;
  logic [WIDTH-1:0] r_cnt_low;
  logic [WIDTH-1:0] r_cnt_per;

  sync_edge_detect u_sync (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clk_in (clk_in),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall)
  );

  // Measurement FSM; a rise in LOW beats a coincident timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt_high <= '0;
      r_cnt_low  <= '0;
      r_cnt_per  <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state    <= HIGH;
            r_cnt_high <= ONE_W;
            r_cnt_low  <= '0;
            r_cnt_per  <= ONE_W;
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_state   <= LOW;
            r_cnt_low <= ONE_W;
            r_cnt_per <= r_cnt_per + ONE_W;
          end else if (r_cnt_per >= TIMEOUT_W) begin
            r_state <= IDLE;
            timeout <= 1'b1;
          end else begin
            r_cnt_high <= r_cnt_high + ONE_W;
            r_cnt_per  <= r_cnt_per + ONE_W;
          end
        end
        LOW: begin
          if (w_rise) begin
            period     <= r_cnt_high + r_cnt_low;
            high_time  <= r_cnt_high;
            valid      <= 1'b1;
            timeout    <= 1'b0;
            r_state    <= HIGH;
            r_cnt_high <= ONE_W;
            r_cnt_low  <= '0;
            r_cnt_per  <= ONE_W;
          end else if (r_cnt_per >= TIMEOUT_W) begin
            r_state <= IDLE;
            timeout <= 1'b1;
          end else begin
            r_cnt_low <= r_cnt_low + ONE_W;
            r_cnt_per <= r_cnt_per + ONE_W;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_measure_clock_period.sv
// Directed bench for measure_clock_period: synchronous square waves with known
// high/low lengths, timeout, timeout-vs-rise priority and reset behaviour.
module tb_measure_clock_period;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_in = 1'b0;
  logic [15:0] period_a, high_a, period_b, high_b;
  logic        valid_a, timeout_a, valid_b, timeout_b;

  int n_total = 0;
  int n_bad   = 0;

  // wave generator state, written by the main thread after posedge
  logic gen_en    = 1'b0;
  logic gen_level = 1'b0;
  int   gen_hi    = 10;
  int   gen_lo    = 30;
  int   gen_cnt   = 0;

  always #5 clk = ~clk;

  measure_clock_period #(.WIDTH(16), .TIMEOUT(100)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .period    (period_a),
    .high_time (high_a),
    .valid     (valid_a),
    .timeout   (timeout_a)
  );

  measure_clock_period #(.WIDTH(16), .TIMEOUT(40)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clk_in),
    .period    (period_b),
    .high_time (high_b),
    .valid     (valid_b),
    .timeout   (timeout_b)
  );

  // Square wave driven on the falling edge so it never races the main thread.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_en) begin
        clk_in  = (gen_cnt < gen_hi);
        gen_cnt = (gen_cnt == gen_hi + gen_lo - 1) ? 0 : gen_cnt + 1;
      end else begin
        clk_in = gen_level;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (valid_a) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start_gen(input int hi, input int lo);
    gen_hi  = hi;
    gen_lo  = lo;
    gen_cnt = 0;
    gen_en  = 1'b1;
  endtask

  task automatic do_reset(input logic level);
    gen_en    = 1'b0;
    gen_level = level;
    rst       = 1'b1;
    repeat (3) tick();
    chk("rst_period", int'(period_a), 0);
    chk("rst_high", int'(high_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_timeout", int'(timeout_a), 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int v_seen;

    // Asymmetric 10/30 wave; dut_b sees its rise exactly at cnt_per == TIMEOUT
    do_reset(1'b0);
    start_gen(10, 30);
    wait_valid(60, n);
    chk("asym_first_lat", n, 43);
    chk("asym_period", int'(period_a), 40);
    chk("asym_high", int'(high_a), 10);
    chk("edge_valid_b", int'(valid_b), 1);
    chk("edge_period_b", int'(period_b), 40);
    chk("edge_high_b", int'(high_b), 10);
    chk("edge_timeout_b", int'(timeout_b), 0);
    tick();
    chk("strobe_width", int'(valid_a), 0);
    wait_valid(60, n);
    chk("asym_spacing", n + 1, 40);
    chk("asym_period2", int'(period_a), 40);
    chk("edge_timeout_b2", int'(timeout_b), 0);

    // Input dies low right after a measurement
    gen_en    = 1'b0;
    gen_level = 1'b0;
    v_seen    = 0;
    for (int i = 1; i <= 99; i++) begin
      tick();
      if (valid_a) v_seen++;
    end
    chk("to_not_early", int'(timeout_a), 0);
    tick();
    if (valid_a) v_seen++;
    chk("to_set", int'(timeout_a), 1);
    chk("to_no_valid", v_seen, 0);
    chk("to_hold_period", int'(period_a), 40);
    chk("to_hold_high", int'(high_a), 10);
    chk("to_set_b", int'(timeout_b), 1);

    // Recovery needs rise, fall, rise from IDLE
    start_gen(10, 30);
    repeat (20) tick();
    chk("to_sticky", int'(timeout_a), 1);
    wait_valid(40, n);
    chk("rec_lat", n, 23);
    chk("rec_timeout_clr", int'(timeout_a), 0);
    chk("rec_period", int'(period_a), 40);

    // Reset pulse in the LOW phase abandons the running period
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("midrst_period", int'(period_a), 0);
    chk("midrst_high", int'(high_a), 0);
    chk("midrst_valid", int'(valid_a), 0);
    chk("midrst_timeout", int'(timeout_a), 0);
    rst = 1'b0;
    wait_valid(80, n);
    chk("midrst_lat", n, 59);
    chk("midrst_period2", int'(period_a), 40);
    chk("midrst_high2", int'(high_a), 10);

    // Divide-by-33 style symmetric wave
    do_reset(1'b0);
    start_gen(33, 33);
    wait_valid(100, n);
    chk("div33_lat", n, 69);
    chk("div33_period", int'(period_a), 66);
    chk("div33_high", int'(high_a), 33);
    for (int k = 0; k < 2; k++) begin
      wait_valid(100, n);
      chk("div33_spacing", n, 66);
      chk("div33_period_n", int'(period_a), 66);
    end

    // Input already high while in reset
    do_reset(1'b1);
    start_gen(10, 30);
    wait_valid(60, n);
    chk("hirst_lat", n, 43);
    chk("hirst_period", int'(period_a), 40);
    chk("hirst_high", int'(high_a), 10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
